mem_xbar_rr: RTL and testbench

Parametrised PE-to-SRAM-bank crossbar that replaces the fixed-priority, combinational-only crossbar. Each bank gets its own round-robin arbiter with a stall handshake (gnt) back to each PE. Read data is steered back to the requesting PE after the bank's fixed read latency. Sits between the N PE data ports and the banked instr/data SRAM.

---
 rtl/mem_xbar_rr_pkg.sv | 24 ++
 rtl/mem_xbar_rr_if.sv | 38 +++
 rtl/mem_xbar_rr_arb.sv | 56 +++++
 rtl/mem_xbar_rr_chk.sv | 31 +++
 rtl/mem_xbar_rr.sv | 119 +++++++++++
 tb/tb_mem_xbar_rr.sv | 324 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_xbar_rr_pkg.sv
// Shared defaults, return-pipe entry type and bank-field helper for the
// round-robin PE-to-SRAM-bank crossbar.
package mem_xbar_pkg;

  localparam int DEF_N_PE     = 4;
  localparam int DEF_N_BANK   = 4;
  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_BANK_LSB = 14;
  localparam int DEF_RD_LAT   = 1;

  // Wide enough for any realistic PE count; upper bits stay zero.
  localparam int PE_IDX_W = 8;

  typedef struct packed {
    logic                valid;
    logic [PE_IDX_W-1:0] pe_idx;
  } ret_entry_t;

  function automatic int bank_field_w(input int n_bank);
    return (n_bank > 1) ? $clog2(n_bank) : 1;
  endfunction

endpackage

// File: rtl/mem_xbar_rr_if.sv
// PE-side and bank-side bus of the crossbar; slave = crossbar, master = PEs plus SRAM.
interface mem_xbar_rr_if
  import mem_xbar_pkg::*;
#(
  parameter int N_PE   = DEF_N_PE,
  parameter int N_BANK = DEF_N_BANK,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) ();

  logic [N_PE-1:0]            rden_i;
  logic [N_PE-1:0]            wren_i;
  logic [N_PE*DATA_W/8-1:0]   wstrb_i;
  logic [N_PE*ADDR_W-1:0]     addr_i;
  logic [N_PE*DATA_W-1:0]     wdata_i;
  logic [N_PE-1:0]            gnt_o;
  logic [N_PE-1:0]            rvalid_o;
  logic [N_PE*DATA_W-1:0]     rdata_o;
  logic [N_BANK-1:0]          bank_en_o;
  logic [N_BANK*DATA_W/8-1:0] bank_wstrb_o;
  logic [N_BANK*ADDR_W-1:0]   bank_addr_o;
  logic [N_BANK*DATA_W-1:0]   bank_wdata_o;
  logic [N_BANK*N_PE-1:0]     bank_peid_o;
  logic [N_BANK*DATA_W-1:0]   bank_rdata_i;

  modport slave (
    input  rden_i, wren_i, wstrb_i, addr_i, wdata_i, bank_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output bank_en_o, bank_wstrb_o, bank_addr_o, bank_wdata_o, bank_peid_o
  );

  modport master (
    output rden_i, wren_i, wstrb_i, addr_i, wdata_i, bank_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  bank_en_o, bank_wstrb_o, bank_addr_o, bank_wdata_o, bank_peid_o
  );

endinterface

// File: rtl/mem_xbar_rr_arb.sv
// N-input round-robin arbiter: one-hot combinational grant, search starts at a
// registered pointer that moves just past the last winner.
module rr_arb
  import mem_xbar_pkg::*;
#(
  parameter int N = DEF_N_PE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int            PW     = (N > 1) ? $clog2(N) : 1;
  localparam int            IW     = PW + 1;
  localparam logic [IW-1:0] N_L    = IW'(N);
  localparam logic [PW-1:0] LAST_L = PW'(N - 1);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] ptr_nxt_s;
  logic [IW-1:0] idx_s;
  logic          found_s;

  // Scan upward from ptr_r modulo N; the first requester wins.
  always_comb begin
    gnt       = '0;
    ptr_nxt_s = ptr_r;
    found_s   = 1'b0;
    idx_s     = '0;
    for (int i = 0; i < N; i++) begin
      idx_s = {1'b0, ptr_r} + IW'(i);
      if (idx_s >= N_L) begin
        idx_s = idx_s - N_L;
      end else begin
        idx_s = idx_s;
      end
      if (!found_s && req[idx_s[PW-1:0]]) begin
        found_s            = 1'b1;
        gnt[idx_s[PW-1:0]] = 1'b1;
        ptr_nxt_s          = (idx_s[PW-1:0] == LAST_L) ? '0 : idx_s[PW-1:0] + PW'(1);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Pointer register; holds when nobody was granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_r <= '0;
    end else begin
      ptr_r <= ptr_nxt_s;
    end
  end

endmodule

// File: rtl/mem_xbar_rr_chk.sv
// Simulation checker: a PE may receive at most one read return per cycle.
module mem_xbar_rr_chk #(
  parameter int N_PE   = 4,
  parameter int N_BANK = 4
) (
  input logic                   clk,
  input logic                   rst,
  input logic [N_BANK*N_PE-1:0] ret_hit
);

  logic [N_BANK-1:0] col_s [N_PE];
  logic [N_PE-1:0]   ret_ok_s;

  // Gather, per PE, which banks are returning to it.
  always_comb begin
    for (int p = 0; p < N_PE; p++) begin
      for (int b = 0; b < N_BANK; b++) begin
        col_s[p][b] = ret_hit[b*N_PE + p];
      end
      ret_ok_s[p] = $onehot0(col_s[p]);
    end
  end

  // Flag any cycle where two banks steer data to the same PE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (&ret_ok_s) else $error("mem_xbar_rr: read return collision, ok vector %b", ret_ok_s);
    end
  end

endmodule

// File: rtl/mem_xbar_rr.sv
// PE-to-SRAM-bank crossbar: per-bank round-robin arbitration with gnt stall,
// and per-bank return pipes that steer read data back after RD_LAT cycles.
module mem_xbar_rr
  import mem_xbar_pkg::*;
#(
  parameter int N_PE     = DEF_N_PE,
  parameter int N_BANK   = DEF_N_BANK,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int BANK_LSB = DEF_BANK_LSB,
  parameter int RD_LAT   = DEF_RD_LAT
) (
  input logic          clk,
  input logic          rst,
  mem_xbar_rr_if.slave bus
);

  localparam int BW = bank_field_w(N_BANK);
  localparam int SW = DATA_W / 8;

  logic [N_PE-1:0]         req_s;
  logic [BW-1:0]           bank_sel_s  [N_PE];
  logic [N_PE-1:0]         arb_req_s   [N_BANK];
  logic [N_PE-1:0]         arb_gnt_s   [N_BANK];
  logic [N_BANK-1:0]       issue_rd_s;
  logic [PE_IDX_W-1:0]     issue_idx_s [N_BANK];
  logic [N_BANK*N_PE-1:0]  ret_hit_s;
  ret_entry_t              pipe_r      [N_BANK][RD_LAT];

  // Decode each PE's request and target bank; reset masks all requests.
  always_comb begin
    for (int p = 0; p < N_PE; p++) begin
      req_s[p]      = bus.rden_i[p] | bus.wren_i[p];
      bank_sel_s[p] = bus.addr_i[p*ADDR_W + BANK_LSB +: BW];
    end
    for (int b = 0; b < N_BANK; b++) begin
      for (int p = 0; p < N_PE; p++) begin
        arb_req_s[b][p] = !rst && req_s[p] && (bank_sel_s[p] == BW'(b));
      end
    end
  end

  for (genvar b = 0; b < N_BANK; b++) begin : g_arb
    rr_arb #(.N(N_PE)) u_arb (
      .clk (clk),
      .rst (rst),
      .req (arb_req_s[b]),
      .gnt (arb_gnt_s[b])
    );
  end

  // Grants are one-hot per bank, so an AND-OR mux selects the winner's fields.
  always_comb begin
    bus.gnt_o        = '0;
    bus.bank_en_o    = '0;
    bus.bank_wstrb_o = '0;
    bus.bank_addr_o  = '0;
    bus.bank_wdata_o = '0;
    bus.bank_peid_o  = '0;
    issue_rd_s       = '0;
    for (int b = 0; b < N_BANK; b++) begin
      issue_idx_s[b] = '0;
      for (int p = 0; p < N_PE; p++) begin
        bus.bank_en_o[b]                 = bus.bank_en_o[b] | arb_gnt_s[b][p];
        bus.bank_wstrb_o[b*SW +: SW]     = bus.bank_wstrb_o[b*SW +: SW]
                                         | ({SW{arb_gnt_s[b][p] & bus.wren_i[p]}} & bus.wstrb_i[p*SW +: SW]);
        bus.bank_addr_o[b*ADDR_W +: ADDR_W] = bus.bank_addr_o[b*ADDR_W +: ADDR_W]
                                         | ({ADDR_W{arb_gnt_s[b][p]}} & bus.addr_i[p*ADDR_W +: ADDR_W]);
        bus.bank_wdata_o[b*DATA_W +: DATA_W] = bus.bank_wdata_o[b*DATA_W +: DATA_W]
                                         | ({DATA_W{arb_gnt_s[b][p]}} & bus.wdata_i[p*DATA_W +: DATA_W]);
        bus.bank_peid_o[b*N_PE + p]      = arb_gnt_s[b][p];
        bus.gnt_o[p]                     = bus.gnt_o[p] | arb_gnt_s[b][p];
        issue_rd_s[b]                    = issue_rd_s[b]
                                         | (arb_gnt_s[b][p] & bus.rden_i[p] & ~bus.wren_i[p]);
        issue_idx_s[b]                   = issue_idx_s[b]
                                         | ({PE_IDX_W{arb_gnt_s[b][p]}} & PE_IDX_W'(p));
      end
    end
  end

  // Return pipes: a granted pure read enters stage 0 and emerges after RD_LAT cycles.
  always_ff @(posedge clk) begin
    for (int b = 0; b < N_BANK; b++) begin
      if (rst) begin
        for (int s = 0; s < RD_LAT; s++) begin
          pipe_r[b][s] <= '0;
        end
      end else begin
        pipe_r[b][0] <= '{valid: issue_rd_s[b], pe_idx: issue_idx_s[b]};
        for (int s = 1; s < RD_LAT; s++) begin
          pipe_r[b][s] <= pipe_r[b][s-1];
        end
      end
    end
  end

  // Steer each pipe tail to its PE; rdata is zero whenever rvalid is low.
  always_comb begin
    bus.rvalid_o = '0;
    bus.rdata_o  = '0;
    ret_hit_s    = '0;
    for (int b = 0; b < N_BANK; b++) begin
      for (int p = 0; p < N_PE; p++) begin
        ret_hit_s[b*N_PE + p] = !rst && pipe_r[b][RD_LAT-1].valid
                                && (pipe_r[b][RD_LAT-1].pe_idx == PE_IDX_W'(p));
        bus.rvalid_o[p] = bus.rvalid_o[p] | ret_hit_s[b*N_PE + p];
        bus.rdata_o[p*DATA_W +: DATA_W] = bus.rdata_o[p*DATA_W +: DATA_W]
            | ({DATA_W{ret_hit_s[b*N_PE + p]}} & bus.bank_rdata_i[b*DATA_W +: DATA_W]);
      end
    end
  end

  mem_xbar_rr_chk #(.N_PE(N_PE), .N_BANK(N_BANK)) u_chk (
    .clk     (clk),
    .rst     (rst),
    .ret_hit (ret_hit_s)
  );

endmodule

// File: tb/tb_mem_xbar_rr.sv
// Bench for mem_xbar_rr: directed scenarios then constrained-random traffic,
// all checked against a spec-level model (rotating priority, byte-lane memory, return queue).
module tb_mem_xbar_rr;
  import mem_xbar_pkg::*;

  localparam int N_PE     = 4;
  localparam int N_BANK   = 4;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int BANK_LSB = 14;
  localparam int RD_LAT   = 2;
  localparam int SW       = DATA_W / 8;
  localparam int WORDS    = 16;

  typedef struct {
    int                due;
    int                pe;
    logic [DATA_W-1:0] data;
  } ret_t;

  logic clk;
  logic rst;

  mem_xbar_rr_if #(.N_PE(N_PE), .N_BANK(N_BANK), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_xbar_rr #(
    .N_PE(N_PE), .N_BANK(N_BANK), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .BANK_LSB(BANK_LSB), .RD_LAT(RD_LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_word(input int b, input int w);
    return {8'hA5, 8'(b), 8'(w), 8'h5A};
  endfunction

  // ---------------- SRAM bank model (environment) ----------------
  logic [DATA_W-1:0] sram  [N_BANK][WORDS];
  logic [DATA_W-1:0] rpipe [N_BANK][RD_LAT];

  always @(posedge clk) begin
    for (int b = 0; b < N_BANK; b++) begin
      if (rst) begin
        for (int w = 0; w < WORDS; w++) sram[b][w] <= init_word(b, w);
        rpipe[b][0] <= {16'hBAD0, 16'(b)};
      end else begin
        for (int k = 0; k < SW; k++)
          if (bus.bank_en_o[b] && bus.bank_wstrb_o[b*SW + k])
            sram[b][bus.bank_addr_o[b*ADDR_W + 2 +: 4]][k*8 +: 8] <= bus.bank_wdata_o[b*DATA_W + k*8 +: 8];
        if (bus.bank_en_o[b] && (bus.bank_wstrb_o[b*SW +: SW] == '0))
          rpipe[b][0] <= sram[b][bus.bank_addr_o[b*ADDR_W + 2 +: 4]];
        else
          rpipe[b][0] <= {16'hBAD0, 16'(b)};
      end
      for (int s = 1; s < RD_LAT; s++) rpipe[b][s] <= rpipe[b][s-1];
    end
  end

  always_comb begin
    for (int b = 0; b < N_BANK; b++) bus.bank_rdata_i[b*DATA_W +: DATA_W] = rpipe[b][RD_LAT-1];
  end

  // ---------------- stimulus, reference model, scoreboard ----------------
  logic              rd [N_PE];
  logic              wr [N_PE];
  logic [SW-1:0]     st [N_PE];
  logic [ADDR_W-1:0] ad [N_PE];
  logic [DATA_W-1:0] wd [N_PE];
  logic              m_gnt [N_PE];

  int                ptr_m   [N_BANK];
  logic [DATA_W-1:0] ref_mem [N_BANK][WORDS];
  ret_t              exp_q   [$];
  int                cyc;
  int                n_assert;
  int                n_fail;

  logic [N_PE-1:0]          obs_gnt;
  logic [N_PE-1:0]          obs_rv;
  logic [N_PE*DATA_W-1:0]   obs_rdata;
  logic [N_BANK*SW-1:0]     obs_wstrb;

  function automatic int bank_of(input logic [ADDR_W-1:0] a);
    return int'((a >> BANK_LSB) % N_BANK);
  endfunction

  function automatic int word_of(input logic [ADDR_W-1:0] a);
    return int'((a >> 2) % WORDS);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle_all();
    for (int p = 0; p < N_PE; p++) begin
      rd[p] = 1'b0; wr[p] = 1'b0; st[p] = '0; ad[p] = '0; wd[p] = '0;
    end
  endtask

  task automatic set_req(input int p, input logic r, input logic w, input logic [SW-1:0] s,
                         input int b, input int word, input logic [DATA_W-1:0] d);
    rd[p] = r; wr[p] = w; st[p] = s; wd[p] = d;
    ad[p] = (ADDR_W'(b) << BANK_LSB) | (ADDR_W'(word) << 2);
  endtask

  task automatic new_req(input int p);
    int kind;
    kind  = int'($urandom_range(0, 7));
    rd[p] = (kind >= 2 && kind <= 4) || kind == 7;
    wr[p] = (kind >= 5);
    st[p] = SW'($urandom);
    ad[p] = $urandom;
    wd[p] = $urandom;
  endtask

  // One clock: drive inputs, check DUT against the model at negedge, advance the model.
  task automatic tick();
    logic [N_PE-1:0]          e_gnt, e_rv;
    logic [N_PE*DATA_W-1:0]   e_rdata;
    logic [N_BANK-1:0]        e_en;
    logic [N_BANK*SW-1:0]     e_strb;
    logic [N_BANK*ADDR_W-1:0] e_addr;
    logic [N_BANK*DATA_W-1:0] e_wdata;
    logic [N_BANK*N_PE-1:0]   e_peid;
    int                       win [N_BANK];
    for (int p = 0; p < N_PE; p++) begin
      bus.rden_i[p] = rd[p];
      bus.wren_i[p] = wr[p];
      bus.wstrb_i[p*SW +: SW] = st[p];
      bus.addr_i[p*ADDR_W +: ADDR_W] = ad[p];
      bus.wdata_i[p*DATA_W +: DATA_W] = wd[p];
      m_gnt[p] = 1'b0;
    end
    @(negedge clk);
    e_gnt = '0; e_rv = '0; e_rdata = '0; e_en = '0; e_strb = '0;
    e_addr = '0; e_wdata = '0; e_peid = '0;
    for (int b = 0; b < N_BANK; b++) win[b] = -1;
    if (rst) begin
      exp_q.delete();
      for (int b = 0; b < N_BANK; b++) begin
        ptr_m[b] = 0;
        for (int w = 0; w < WORDS; w++) ref_mem[b][w] = init_word(b, w);
      end
    end else begin
      for (int b = 0; b < N_BANK; b++) begin
        for (int i = 0; i < N_PE; i++) begin
          int p;
          p = (ptr_m[b] + i) % N_PE;
          if (win[b] < 0 && (rd[p] || wr[p]) && bank_of(ad[p]) == b) win[b] = p;
        end
        if (win[b] >= 0) begin
          e_gnt[win[b]] = 1'b1;
          e_en[b] = 1'b1;
          e_strb[b*SW +: SW] = wr[win[b]] ? st[win[b]] : '0;
          e_addr[b*ADDR_W +: ADDR_W] = ad[win[b]];
          e_wdata[b*DATA_W +: DATA_W] = wd[win[b]];
          e_peid[b*N_PE + win[b]] = 1'b1;
        end
      end
      foreach (exp_q[i]) begin
        if (exp_q[i].due == cyc) begin
          e_rv[exp_q[i].pe] = 1'b1;
          e_rdata[exp_q[i].pe*DATA_W +: DATA_W] = exp_q[i].data;
        end
      end
    end
    obs_gnt = bus.gnt_o; obs_rv = bus.rvalid_o; obs_rdata = bus.rdata_o; obs_wstrb = bus.bank_wstrb_o;
    chk("gnt",        128'(obs_gnt),          128'(e_gnt));
    chk("bank_en",    128'(bus.bank_en_o),    128'(e_en));
    chk("bank_wstrb", 128'(obs_wstrb),        128'(e_strb));
    chk("bank_addr",  128'(bus.bank_addr_o),  128'(e_addr));
    chk("bank_wdata", 128'(bus.bank_wdata_o), 128'(e_wdata));
    chk("bank_peid",  128'(bus.bank_peid_o),  128'(e_peid));
    chk("rvalid",     128'(obs_rv),           128'(e_rv));
    chk("rdata",      128'(obs_rdata),        128'(e_rdata));
    if (!rst) begin
      for (int b = 0; b < N_BANK; b++) begin
        if (win[b] >= 0) begin
          int p, w;
          p = win[b];
          w = word_of(ad[p]);
          if (wr[p]) begin
            for (int k = 0; k < SW; k++)
              if (st[p][k]) ref_mem[b][w][k*8 +: 8] = wd[p][k*8 +: 8];
          end else begin
            exp_q.push_back('{due: cyc + RD_LAT, pe: p, data: ref_mem[b][w]});
          end
          ptr_m[b] = (p + 1) % N_PE;
          m_gnt[p] = 1'b1;
        end
      end
      for (int i = exp_q.size() - 1; i >= 0; i--)
        if (exp_q[i].due == cyc) exp_q.delete(i);
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle_all();
    repeat (n) tick();
    rst = 1'b0;
  endtask

  initial begin
    logic              any_rv;
    logic              rv0   [6];
    logic [DATA_W-1:0] data0 [6];
    n_assert = 0; n_fail = 0; cyc = 0;
    rst = 1'b1;
    idle_all();

    // Reset state, then all four PEs read distinct banks in one cycle.
    do_reset(2);
    for (int p = 0; p < N_PE; p++) set_req(p, 1'b1, 1'b0, '0, p, p, '0);
    tick();
    chk("t1_gnt_all", 128'(obs_gnt), 128'(4'b1111));
    idle_all();
    repeat (RD_LAT - 1) tick();
    tick();
    chk("t1_rv_all", 128'(obs_rv), 128'(4'b1111));
    chk("t1_rdata_pe2", 128'(obs_rdata[2*DATA_W +: DATA_W]), 128'(init_word(2, 2)));

    // Four PEs hold reads to bank 2: grants rotate 0,1,2,3,0,1,2,3.
    do_reset(1);
    for (int p = 0; p < N_PE; p++) set_req(p, 1'b1, 1'b0, '0, 2, p, '0);
    for (int i = 0; i < 8; i++) begin
      logic [N_PE-1:0] want;
      want = '0;
      want[i % N_PE] = 1'b1;
      tick();
      chk("t2_rotate", 128'(obs_gnt), 128'(want));
    end
    idle_all();
    repeat (RD_LAT + 1) tick();

    // PE1 write vs PE3 read on bank 1 with ptr 0.
    do_reset(1);
    set_req(1, 1'b0, 1'b1, 4'b0011, 1, 3, 32'h1122_3344);
    set_req(3, 1'b1, 1'b0, '0, 1, 3, '0);
    tick();
    chk("t3_gnt_wr", 128'(obs_gnt), 128'(4'b0010));
    chk("t3_wstrb", 128'(obs_wstrb[1*SW +: SW]), 128'(4'b0011));
    set_req(1, 1'b0, 1'b0, '0, 0, 0, '0);
    tick();
    chk("t3_gnt_rd", 128'(obs_gnt), 128'(4'b1000));
    idle_all();
    tick();
    tick();
    chk("t3_rv", 128'(obs_rv), 128'(4'b1000));
    chk("t3_rdata", 128'(obs_rdata[3*DATA_W +: DATA_W]), 128'(32'hA501_3344));

    // rden and wren together is a write with no read return.
    set_req(0, 1'b1, 1'b1, 4'hF, 0, 5, 32'hCAFE_F00D);
    tick();
    chk("t4_gnt", 128'(obs_gnt), 128'(4'b0001));
    idle_all();
    any_rv = 1'b0;
    repeat (RD_LAT + 1) begin
      tick();
      any_rv = any_rv | obs_rv[0];
    end
    chk("t4_no_rv", 128'(any_rv), 128'(1'b0));

    // Reset one cycle after a read grant drops the in-flight read.
    set_req(2, 1'b1, 1'b0, '0, 3, 1, '0);
    tick();
    chk("t5_gnt", 128'(obs_gnt), 128'(4'b0100));
    do_reset(1);
    any_rv = 1'b0;
    repeat (RD_LAT + 1) begin
      tick();
      any_rv = any_rv | (|obs_rv);
    end
    chk("t5_dropped", 128'(any_rv), 128'(1'b0));
    for (int p = 0; p < N_PE; p++) set_req(p, 1'b1, 1'b0, '0, 3, p, '0);
    tick();
    chk("t5_pe0_wins", 128'(obs_gnt), 128'(4'b0001));
    idle_all();
    repeat (RD_LAT + 1) tick();

    // PE0 streams reads to bank 0 at addresses 0, 4, 8.
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      if (k < 3) set_req(0, 1'b1, 1'b0, '0, 0, k, '0);
      else idle_all();
      tick();
      rv0[k]   = obs_rv[0];
      data0[k] = obs_rdata[0 +: DATA_W];
    end
    chk("t6_rv_before", 128'(rv0[1]), 128'(1'b0));
    for (int k = 0; k < 3; k++) begin
      chk("t6_rv_stream", 128'(rv0[k + RD_LAT]), 128'(1'b1));
      chk("t6_data_stream", 128'(data0[k + RD_LAT]), 128'(init_word(0, k)));
    end
    chk("t6_rv_after", 128'(rv0[5]), 128'(1'b0));

    // Random traffic: a stalled PE holds its request until the model grants it.
    do_reset(1);
    for (int c = 0; c < 400; c++) begin
      for (int p = 0; p < N_PE; p++)
        if (!(rd[p] || wr[p]) || m_gnt[p]) new_req(p);
      tick();
    end
    idle_all();
    repeat (RD_LAT + 1) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
